// File: rtl/fp32_to_fixed_if.sv
// fp32_to_fixed_if: valid/ready handshake bundle for the FP32 -> fixed-point converter.
//   in_valid/in_ready/in_data    : FP32 word from the producer
//   out_valid/out_ready/out_data : signed W-bit fixed-point result to the consumer
//   out_ovf                      : result was out of range or came from Inf/NaN
// master = producer/consumer side (testbench or surrounding logic), slave = converter.
interface fp32_to_fixed_if #(
  parameter int unsigned W = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/fp32_to_fixed.sv
// fp32_to_fixed: sequential IEEE-754 single-precision to signed Q-format converter.
// The mantissa is aligned by a one-bit-per-cycle shifter; one conversion in flight.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fp32_to_fixed_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/
//          out_data/out_ovf)
// Parameters: W (output width, 25..32), FRAC (fractional bits, 0..W-1).
// Build option: define FP2FIX_SATURATE_EN to saturate out_data on overflow
// (NaN -> 0); otherwise out_data wraps and Inf/NaN/huge exponents give 0.
module fp32_to_fixed #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 16
) (
  input  logic                clk,
  input  logic                rst,
  fp32_to_fixed_if.slave      bus
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned EXP_SW = 11;
  localparam int unsigned RSH_MAX = 25;
  localparam logic [W-1:0] MIN_MAG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    SHIFT  = 3'd2,
    PACK   = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         word_q, word_d;
  logic [W-1:0]        mag_q, mag_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                left_q, left_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        out_data_q, out_data_d;
  logic                out_ovf_q, out_ovf_d;

  // Field views of the latched word; the word is held until the next accept.
  logic                sign;
  logic [7:0]          expo;
  logic [22:0]         man;
  logic signed [EXP_SW-1:0] s_dec;
  logic signed [EXP_SW-1:0] s_neg;
  logic                ovf_pack;
  logic [W-1:0]        res_pack;

  assign sign  = word_q[31];
  assign expo  = word_q[30:23];
  assign man   = word_q[22:0];
  // Shift amount: positive = left shift, negative = right shift.
  assign s_dec = $signed({3'b000, expo}) - EXP_SW'(150) + $signed(EXP_SW'(FRAC));
  assign s_neg = -s_dec;

  // Range check and sign application on the aligned magnitude.
  always_comb begin
    ovf_pack = ovf_q | (~sign & mag_q[W-1]) | (sign & (mag_q > MIN_MAG));
    res_pack = sign ? (~mag_q + W'(1)) : mag_q;
`ifdef FP2FIX_SATURATE_EN
    if ((expo == 8'hFF) && (man != 23'd0)) begin
      res_pack = '0;
    end else if (ovf_pack) begin
      res_pack = sign ? MIN_MAG : ~MIN_MAG;
    end
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          state_d = DECODE;
        end
      end

      DECODE: begin
        mag_d  = '0;
        cnt_d  = '0;
        left_d = 1'b0;
        ovf_d  = 1'b0;
        if (expo == 8'd0) begin
          // zero and denormals flush to zero
        end else if (expo == 8'hFF) begin
          ovf_d = 1'b1;
        end else if (s_dec < 0) begin
          mag_d = W'({1'b1, man});
          cnt_d = (s_neg > $signed(EXP_SW'(RSH_MAX))) ? CNT_W'(RSH_MAX) : CNT_W'(s_neg);
        end else if (s_dec <= $signed(EXP_SW'(W - 1))) begin
          mag_d  = W'({1'b1, man});
          left_d = 1'b1;
          cnt_d  = CNT_W'(s_dec);
        end else begin
          ovf_d = 1'b1;
        end
        state_d = (cnt_d != '0) ? SHIFT : PACK;
      end

      SHIFT: begin
        if (left_q) begin
          // a one leaving the top bit makes the result unrepresentable
          if (mag_q[W-1]) ovf_d = 1'b1;
          mag_d = mag_q << 1;
        end else begin
          mag_d = mag_q >> 1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = PACK;
      end

      PACK: begin
        out_data_d = res_pack;
        out_ovf_d  = ovf_pack;
        state_d    = OUT;
      end

      OUT: begin
        // out_valid rises one cycle after entering OUT and drops on handshake
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      mag_q       <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fp32_to_fixed.sv
// tb_fp32_to_fixed: directed-vector bench for fp32_to_fixed (W=32, FRAC=16).
// An arithmetic reference model predicts every result; a compare process checks the
// DUT outputs against it on each cycle out_valid is high, and literal expectations
// pin both the model and the DUT.
module tb_fp32_to_fixed;

  localparam int W    = 32;
  localparam int FRAC = 16;

  typedef struct {
    logic [31:0] d;
    logic        o;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] d_wrap;
    logic [31:0] d_sat;
    logic        o;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  vec_t vecs[14];

  fp32_to_fixed_if #(.W(W)) bus ();

  fp32_to_fixed #(.W(W), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Reference: exact value * 2^FRAC truncated toward zero, using wide integers.
  function automatic void model(input logic [31:0] w, output logic [31:0] d,
                                output logic o, output int n);
    logic         sg;
    int           e;
    int           s;
    logic [255:0] full;
    logic [255:0] sv;
    logic [255:0] lim;
    logic         nan;
    sg   = w[31];
    e    = int'(w[30:23]);
    nan  = (e == 255) && (w[22:0] != 23'd0);
    lim  = 256'(1) << (W - 1);
    d    = '0;
    o    = 1'b0;
    n    = 0;
    full = '0;
    if (e == 255) begin
      o = 1'b1;
    end else if (e != 0) begin
      s = e - 150 + FRAC;
      if (s > W - 1) begin
        o = 1'b1;
      end else begin
        if (s < 0) begin
          full = 256'({1'b1, w[22:0]}) >> (-s);
          n    = (-s > 25) ? 25 : -s;
        end else begin
          full = 256'({1'b1, w[22:0]}) << s;
          n    = s;
        end
        if (!sg && full >= lim) o = 1'b1;
        if (sg && full > lim) o = 1'b1;
        sv = sg ? (~full + 256'(1)) : full;
        d  = sv[31:0];
      end
    end
`ifdef FP2FIX_SATURATE_EN
    if (nan) d = '0;
    else if (o) d = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    if (nan) d = '0;
`endif
  endfunction

  // Per-cycle compare against the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got data 0x%08h ovf %0b with nothing pending",
                 bus.out_data, bus.out_ovf);
      end else begin
        if (bus.out_data !== exp_q[0].d || bus.out_ovf !== exp_q[0].o) begin
          errors++;
          $display("FAIL model_compare: got 0x%08h ovf %0b required 0x%08h ovf %0b",
                   bus.out_data, bus.out_ovf, exp_q[0].d, exp_q[0].o);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_conv(input logic [31:0] w, input logic [31:0] xd, input logic xo,
                         input int xlat, input int hold);
    logic [31:0] md;
    logic        mo;
    int          mn;
    int          lat;
    model(w, md, mo, mn);
    chk("model_data", md, xd);
    chk("model_ovf", 32'(mo), 32'(xo));
    chk("model_latency", 32'(mn + 3), 32'(xlat));
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_data   = w;
    bus.out_ready = 1'b0;
    wait_idle();
    @(posedge clk);
    exp_q.push_back('{md, mo});
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 100);
    chk("latency", 32'(lat), 32'(xlat));
    chk("out_data", bus.out_data, xd);
    chk("out_ovf", 32'(bus.out_ovf), 32'(xo));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] xd;
    int          seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    //            word          wrap           saturate       ovf  latency
    vecs[0]  = '{32'h3F800000, 32'h00010000, 32'h00010000, 1'b0, 10};  // 1.0
    vecs[1]  = '{32'hC0200000, 32'hFFFD8000, 32'hFFFD8000, 1'b0,  9};  // -2.5
    vecs[2]  = '{32'h358637BD, 32'h00000000, 32'h00000000, 1'b0, 28};  // 1e-6
    vecs[3]  = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0,  3};  // -0.0
    vecs[4]  = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0,  3};  // denormal
    vecs[5]  = '{32'h46FFFF00, 32'h7FFF8000, 32'h7FFF8000, 1'b0, 10};  // 32767.5
    vecs[6]  = '{32'h47800000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 12};  // 65536.0
    vecs[7]  = '{32'h7F800000, 32'h00000000, 32'h7FFFFFFF, 1'b1,  3};  // +Inf
    vecs[8]  = '{32'hC7000000, 32'h80000000, 32'h80000000, 1'b0, 11};  // -32768.0
    vecs[9]  = '{32'h47000000, 32'h80000000, 32'h7FFFFFFF, 1'b1, 11};  // +32768.0
    vecs[10] = '{32'hC7800000, 32'h00000000, 32'h80000000, 1'b1, 12};  // -65536.0
    vecs[11] = '{32'h7FC00000, 32'h00000000, 32'h00000000, 1'b1,  3};  // NaN
    vecs[12] = '{32'hFF000000, 32'h00000000, 32'h80000000, 1'b1,  3};  // -huge
    vecs[13] = '{32'h3F000000, 32'h00008000, 32'h00008000, 1'b0, 11};  // 0.5

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_out_ovf", 32'(bus.out_ovf), 32'd0);

    for (int i = 0; i < 14; i++) begin
`ifdef FP2FIX_SATURATE_EN
      xd = vecs[i].d_sat;
`else
      xd = vecs[i].d_wrap;
`endif
      do_conv(vecs[i].w, xd, vecs[i].o, vecs[i].lat, (i == 5) ? 5 : 0);
    end

    // reset during SHIFT: accept 1.0, reset sampled on edge 4 after accept
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F800000;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", bus.out_data, 32'd0);
    chk("midrst_out_ovf", 32'(bus.out_ovf), 32'd0);
    #4 rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);

    // reset and in_valid in the same cycle: nothing may be captured
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F800000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("rst_vs_valid_no_output", 32'(seen), 32'd0);
    chk("rst_vs_valid_in_ready", 32'(bus.in_ready), 32'd1);

    do_conv(32'hC0200000, 32'hFFFD8000, 1'b0, 9, 0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_to_fixed.md
# fp32_to_fixed

Sequential IEEE-754 single-precision to signed fixed-point converter. It decodes a packed FP32 word into sign, exponent and mantissa, aligns the mantissa with an iterative one-bit-per-cycle shifter, and emits a two's-complement Q-format value. It sits between the floating-point datapath (adder outputs, stored weights) and the fixed-point neuron/activation logic of the neural-network core. It uses a valid/ready handshake on both sides.

## Interface
- `W`, 32: output width in bits. Legal range is 25 to 32.
- `FRAC`, 16: number of fractional bits in the output. Legal range is 0 to W-1.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block can accept a word. It is high only in IDLE.
- `in_data` input 32: FP32 word, laid out as {sign, exp[7:0], man[22:0]}.
- `out_valid` output 1: `out_data` and `out_ovf` are valid.
- `out_ready` input 1: the consumer accepts the result.
- `out_data` output W: signed fixed-point result.
- `out_ovf` output 1: the input was out of range or was Inf/NaN.

## Operation
- **FSM states:** IDLE, DECODE, SHIFT, PACK, OUT.
- **IDLE:** `in_ready`=1. On `in_valid`, latch `in_data` and go to DECODE.
- **DECODE (1 cycle):**
  - exp==0 (zero or denormal): magnitude=0 and n=0. Denormals flush to zero.
  - exp==255 (Inf/NaN): set ovf and n=0.
  - Otherwise: mag={1,man}, zero-extended to W bits, and s = exp − 150 + FRAC.
  - s<0: right shift, with n=min(−s, 25).
  - 0≤s≤W−1: left shift, with n=s.
  - s>W−1: set ovf and n=0.
  - Next state is SHIFT if n>0, else PACK.
- **SHIFT (n cycles):**
  - Shift the magnitude one bit per cycle and decrement n.
  - Left shift: if mag[W−1]==1 before the shift, set sticky ovf.
  - Right shift truncates, so values round toward zero.
  - Go to PACK when n reaches 1.
- **PACK (1 cycle):**
  - If sign==0 and mag[W−1]==1, set ovf.
  - If sign==1 and mag>2^(W−1), set ovf.
  - If sign==1, the result is −mag (two's complement); otherwise it is mag.
  - Register the result and go to OUT.
- **OUT:**
  - `out_valid`=1. `out_data` and `out_ovf` stay stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- **Negative zero:** −0.0 produces 0.
- **Other zero results:** any input that yields magnitude 0 produces 0 with ovf=0.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ovf`=0.
- **Latency:** counting the accept edge as edge 0, `out_valid` rises after edge n+3. Bounds:
  - Minimum is 3 cycles (n=0).
  - Maximum is max(25, W−1)+3 cycles.
- **Throughput:** one conversion in flight. There is no input acceptance from DECODE through OUT.
- **Back-to-back transfers:** the OUT→IDLE transition costs one cycle, so the next input is accepted no earlier than the edge after the output handshake.
- **Reset mid-operation:** `rst` in any state returns the block to the reset values at that edge. The in-flight word is discarded and no `out_valid` pulse is produced for it.
- **Reset with a pending input:** `rst` and `in_valid` high in the same cycle: reset wins and nothing is captured.
- **Handshake stability:** `out_valid` deasserts only after a cycle with `out_valid` & `out_ready` both high.

## Configuration
- **`FP2FIX_SATURATE_EN` defined:**
  - When ovf is set, `out_data` saturates: +2^(W−1)−1 for sign=0 and −2^(W−1) for sign=1.
  - NaN (exp=255, man≠0) produces 0.
  - `out_ovf` is still reported.
- **`FP2FIX_SATURATE_EN` undefined:**
  - `out_data` is the low W bits of the signed, shifted value, so it wraps.
  - Inf/NaN and the s>W−1 case produce 0.
  - `out_ovf` is still reported.

## Test plan
All scenarios use W=32 and FRAC=16.
- **Unit value:** 0x3F800000 (1.0) → `out_data`=0x00010000, ovf=0. n=7, so `out_valid` rises 10 cycles after accept.
- **Negative value:** 0xC0200000 (−2.5) → 0xFFFD8000, ovf=0.
- **Underflow and zero:**
  - 0x358637BD (1e−6) → 0x00000000 with n=25 (28-cycle latency).
  - 0x80000000 (−0.0) → 0.
  - 0x00000001 (denormal) → 0 at 3-cycle latency.
- **Range boundary:**
  - 0x46FFFF00 (32767.5) → 0x7FFF8000, ovf=0.
  - 0x47800000 (65536.0) → ovf=1; `out_data`=0x7FFFFFFF with the macro, 0x00000000 without.
  - 0x7F800000 (+Inf) → ovf=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in OUT → `out_valid`, `out_data` and `out_ovf` stay stable and `in_ready`=0. Drive `out_ready`=1 → the state is IDLE on the next cycle.
- **Reset mid-SHIFT:** assert `rst` 4 cycles after accepting 0x3F800000 → all outputs are at reset values on the next edge and no `out_valid` appears. A new 0xC0200000 input then converts correctly.
